lag_scan_scheduler: RTL and testbench

Sequences the correlator integration cycle: clears the counters, holds integration for a programmed number of pllclk cycles, and pulses capture so the packet register latches the counters. It waits for packet transmission to complete, then steps each input's sampling-clock lag (the per-input auto/cross divider value) by its increment, and wraps at start+length. It sits between the command parser (tmp/len/increment/test bits) and the CLK_GEN/COUNTER/TX_WORD datapath.

---
 rtl/lag_scan_scheduler.sv | 170 +++++++++++++++++
 tb/tb_lag_scan_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lag_scan_scheduler.sv
// ---------------------------------------------------------------------------
// lag_scan_scheduler
//
// Runs the correlator integration cycle. Each packet has these phases:
//   clear counters -> integrate for a programmed number of pllclk cycles ->
//   one-cycle capture strobe -> wait for the packet to finish sending ->
//   step every channel's sampling-clock lag by its increment.
// Each lag wraps back to its start value once it would reach start+length.
// A sweep is complete once every channel has wrapped at least once.
//
// Ports
//   pllclk         sole clock, rising edge
//   reset          asynchronous, active-high
//   start          level; high keeps the scheduling loop running
//   single_shot    1 = return to IDLE after the first complete sweep
//   scan_en        per-channel sweep enable
//   lag_tmp_a      per-channel sweep start      (shadowed on IDLE exit)
//   lag_len_a      per-channel sweep length     (shadowed on IDLE exit)
//   lag_inc_a      per-channel step             (shadowed on IDLE exit)
//   integ_cycles   integration length; 0 behaves as 1
//   tx_done        one-cycle pulse, packet fully sent (used in WAIT_TX only)
//   lag_a          current lag per channel, to CLK_GEN
//   counter_reset  clears correlator counters (IDLE and CLEAR)
//   integrating    high during the integration window
//   capture        one-cycle latch strobe to the packet register
//   scan_done      one-cycle pulse after the STEP that completes a sweep
//   busy           high in every state except IDLE
// ---------------------------------------------------------------------------
module lag_scan_scheduler #(
   parameter int NUM_INPUTS   = 8,
   parameter int LAG_WIDTH    = 20,
   parameter int INC_WIDTH    = 12,
   parameter int INTEG_WIDTH  = 24,
   parameter int CLEAR_CYCLES = 4
) (
   input  logic                            pllclk,
   input  logic                            reset,
   input  logic                            start,
   input  logic                            single_shot,
   input  logic [NUM_INPUTS-1:0]           scan_en,
   input  logic [NUM_INPUTS*LAG_WIDTH-1:0] lag_tmp_a,
   input  logic [NUM_INPUTS*LAG_WIDTH-1:0] lag_len_a,
   input  logic [NUM_INPUTS*INC_WIDTH-1:0] lag_inc_a,
   input  logic [INTEG_WIDTH-1:0]          integ_cycles,
   input  logic                            tx_done,
   output logic [NUM_INPUTS*LAG_WIDTH-1:0] lag_a,
   output logic                            counter_reset,
   output logic                            integrating,
   output logic                            capture,
   output logic                            scan_done,
   output logic                            busy
);

   localparam int LW = NUM_INPUTS * LAG_WIDTH;
   localparam int IW = NUM_INPUTS * INC_WIDTH;
   localparam logic [INTEG_WIDTH-1:0] CLEAR_LAST = INTEG_WIDTH'(CLEAR_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, CLEAR, INTEGRATE, CAPTURE, WAIT_TX, STEP
   } state_t;

   state_t                 state, state_nxt;
   logic [LW-1:0]          tmp_q, len_q, lag_q, step_lag;
   logic [IW-1:0]          inc_q;
   logic [NUM_INPUTS-1:0]  wrap_q, step_wrap;
   logic                   all_wrapped;
   logic [INTEG_WIDTH-1:0] cnt_q, integ_last;
   logic                   scan_done_q;
   logic [LAG_WIDTH:0]     end_v, nxt_v;

   // A zero integration length is stretched to one cycle.
   assign integ_last = (integ_cycles == '0) ? '0 : integ_cycles - 1'b1;

   // Next lag per channel. end/nxt carry one extra bit so that a sum past the
   // top of the lag range is seen as a wrap rather than silently truncated.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would infer a latch.
      step_lag = lag_q;
      step_wrap = wrap_q;
      end_v = '0;
      nxt_v = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         end_v = {1'b0, tmp_q[i*LAG_WIDTH +: LAG_WIDTH]} + {1'b0, len_q[i*LAG_WIDTH +: LAG_WIDTH]};
         nxt_v = {1'b0, lag_q[i*LAG_WIDTH +: LAG_WIDTH]}
               + (LAG_WIDTH+1)'(inc_q[i*INC_WIDTH +: INC_WIDTH]);
         if (!scan_en[i] || inc_q[i*INC_WIDTH +: INC_WIDTH] == '0
             || len_q[i*LAG_WIDTH +: LAG_WIDTH] == '0
             || nxt_v >= end_v || nxt_v[LAG_WIDTH]) begin
            step_lag[i*LAG_WIDTH +: LAG_WIDTH] = tmp_q[i*LAG_WIDTH +: LAG_WIDTH];
            step_wrap[i] = 1'b1;
         end else begin
            step_lag[i*LAG_WIDTH +: LAG_WIDTH] = nxt_v[LAG_WIDTH-1:0];
         end
      end
   end

   assign all_wrapped = &step_wrap;

   // State register
   always_ff @(posedge pllclk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start) state_nxt = CLEAR;
         CLEAR:     if (!start) state_nxt = IDLE;
                    else if (cnt_q == CLEAR_LAST) state_nxt = INTEGRATE;
         INTEGRATE: if (!start) state_nxt = IDLE;
                    else if (cnt_q >= integ_last) state_nxt = CAPTURE;
         CAPTURE:   state_nxt = WAIT_TX;
         WAIT_TX:   if (tx_done) state_nxt = STEP;
         STEP:      if (!start || (all_wrapped && single_shot)) state_nxt = IDLE;
                    else state_nxt = CLEAR;
         default:   state_nxt = IDLE;
      endcase
   end

   // Datapath: shadow registers, lags, wrap flags, phase counter
   always_ff @(posedge pllclk or posedge reset) begin
      // NOTE: the shadow and lag registers are ordinary flops, not a RAM, so
      // they take the async reset like the rest of the state.
      if (reset) begin
         tmp_q       <= '0;
         len_q       <= '0;
         inc_q       <= '0;
         lag_q       <= '0;
         wrap_q      <= '0;
         cnt_q       <= '0;
         scan_done_q <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout; every register here samples the
         // pre-edge values of the others.
         scan_done_q <= 1'b0;
         cnt_q <= ((state == CLEAR || state == INTEGRATE) && state_nxt == state)
                  ? cnt_q + 1'b1 : '0;
         case (state)
            IDLE: if (start) begin
               tmp_q  <= lag_tmp_a;
               len_q  <= lag_len_a;
               inc_q  <= lag_inc_a;
               lag_q  <= lag_tmp_a;
               wrap_q <= '0;
            end
            STEP: begin
               lag_q <= step_lag;
               if (all_wrapped) begin
                  wrap_q      <= '0;
                  scan_done_q <= 1'b1;
               end else begin
                  wrap_q <= step_wrap;
               end
            end
            default: ;
         endcase
      end
   end

   assign lag_a         = lag_q;
   assign counter_reset = (state == IDLE) || (state == CLEAR);
   assign integrating   = (state == INTEGRATE);
   assign capture       = (state == CAPTURE);
   assign busy          = (state != IDLE);
   assign scan_done     = scan_done_q;

endmodule

// File: tb/tb_lag_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_lag_scan_scheduler
//
// Two-channel bench. Inputs are driven on the falling edge and outputs are
// sampled on the falling edge, halfway between rising edges. A per-channel
// sweep model (plain integer arithmetic) predicts lag_a and scan_done after
// every STEP. Phase lengths are measured directly from the outputs.
// ---------------------------------------------------------------------------
module tb_lag_scan_scheduler;

   localparam int N  = 2;
   localparam int LW = 20;
   localparam int IW = 12;
   localparam int TW = 24;
   localparam int CC = 4;

   logic              pllclk = 1'b0;
   logic              reset, start, single_shot, tx_done;
   logic [N-1:0]      scan_en;
   logic [N*LW-1:0]   lag_tmp_a, lag_len_a, lag_a;
   logic [N*IW-1:0]   lag_inc_a;
   logic [TW-1:0]     integ_cycles;
   logic              counter_reset, integrating, capture, scan_done, busy;

   int n_cmp = 0;
   int n_bad = 0;

   // sweep model
   longint m_tmp[N], m_len[N], m_inc[N], m_lag[N];
   bit     m_wrap[N], m_en[N];

   lag_scan_scheduler #(
      .NUM_INPUTS(N), .LAG_WIDTH(LW), .INC_WIDTH(IW),
      .INTEG_WIDTH(TW), .CLEAR_CYCLES(CC)
   ) dut (
      .pllclk(pllclk), .reset(reset), .start(start), .single_shot(single_shot),
      .scan_en(scan_en), .lag_tmp_a(lag_tmp_a), .lag_len_a(lag_len_a),
      .lag_inc_a(lag_inc_a), .integ_cycles(integ_cycles), .tx_done(tx_done),
      .lag_a(lag_a), .counter_reset(counter_reset), .integrating(integrating),
      .capture(capture), .scan_done(scan_done), .busy(busy)
   );

   always #5 pllclk = ~pllclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge pllclk);
   endtask

   task automatic set_ch(input int i, input logic [LW-1:0] tmp,
                         input logic [LW-1:0] len, input logic [IW-1:0] inc);
      lag_tmp_a[i*LW +: LW] = tmp;
      lag_len_a[i*LW +: LW] = len;
      lag_inc_a[i*IW +: IW] = inc;
   endtask

   // Model: latch the programmed sweep at the moment start is accepted.
   task automatic model_start();
      for (int i = 0; i < N; i++) begin
         m_tmp[i]  = lag_tmp_a[i*LW +: LW];
         m_len[i]  = lag_len_a[i*LW +: LW];
         m_inc[i]  = lag_inc_a[i*IW +: IW];
         m_en[i]   = scan_en[i];
         m_lag[i]  = m_tmp[i];
         m_wrap[i] = 1'b0;
      end
   endtask

   // Model: one lag step; returns 1 when the sweep completes.
   function automatic bit model_step();
      bit all = 1'b1;
      for (int i = 0; i < N; i++) begin
         longint nxt = m_lag[i] + m_inc[i];
         if (!m_en[i] || m_inc[i] == 0 || m_len[i] == 0 ||
             nxt >= m_tmp[i] + m_len[i] || nxt >= (longint'(1) << LW)) begin
            m_lag[i]  = m_tmp[i];
            m_wrap[i] = 1'b1;
         end else begin
            m_lag[i] = nxt;
         end
         all &= m_wrap[i];
      end
      if (all) for (int i = 0; i < N; i++) m_wrap[i] = 1'b0;
      return all;
   endfunction

   function automatic logic [N*LW-1:0] model_vec();
      logic [N*LW-1:0] v;
      for (int i = 0; i < N; i++) v[i*LW +: LW] = LW'(m_lag[i]);
      return v;
   endfunction

   task automatic check_reset_values(input string tag);
      check({tag, "_lag"}, lag_a, '0);
      check({tag, "_outs"}, {counter_reset, integrating, capture, scan_done, busy}, 5'b10000);
   endtask

   // One packet, entered at the first sampled CLEAR cycle and left at the
   // sample just after the STEP update.
   task automatic packet(input int tx_delay, input bit drop_wait, output bit done);
      int cnt = 0;
      bit bad = 1'b0;
      while (counter_reset && busy && !integrating && cnt < 200) begin
         cnt++;
         tx_done = 1'($urandom_range(0, 1));   // must be ignored outside WAIT_TX
         tick();
      end
      check("clear_cycles", 64'(cnt), 64'(CC));
      cnt = 0;
      while (integrating && cnt < 300) begin
         cnt++;
         if (counter_reset || capture) bad = 1'b1;
         tx_done   = 1'($urandom_range(0, 1));
         lag_tmp_a = (N*LW)'({$urandom, $urandom});  // parser writes mid-run
         lag_len_a = (N*LW)'({$urandom, $urandom});
         lag_inc_a = (N*IW)'($urandom);
         tick();
      end
      check("integ_cycles", 64'(cnt), (integ_cycles == 0) ? 64'd1 : 64'(integ_cycles));
      check("integ_exclusive", 64'(bad), 64'd0);
      check("capture_exclusive", {capture, integrating, counter_reset}, 3'b100);
      tx_done = 1'b0;
      tick();
      check("capture_width", capture, 1'b0);
      if (drop_wait) start = 1'b0;
      repeat (tx_delay) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("lag_before_update", lag_a, model_vec());
      tick();
      done = model_step();
      check("lag_a", lag_a, model_vec());
      check("scan_done", scan_done, done);
      check("busy_after_step", busy, start && !(done && single_shot));
      for (int i = 0; i < N; i++)
         if (m_en[i] && m_len[i] > 0)
            check("lag_in_range",
                  64'(longint'(lag_a[i*LW +: LW]) >= m_tmp[i] &&
                      longint'(lag_a[i*LW +: LW]) < m_tmp[i] + m_len[i]), 64'd1);
   endtask

   // Full sweep from IDLE. A free-running sweep is ended by dropping start
   // in the CLEAR cycle that follows completion.
   task automatic run_sweep(input bit ss, input int tx_lo, input int tx_hi);
      bit done = 1'b0;
      int k = 0;
      single_shot = ss;
      start = 1'b1;
      model_start();
      tick();
      check("load_lag", lag_a, model_vec());
      check("busy_run", busy, 1'b1);
      while (!done && k < 40) begin
         packet($urandom_range(tx_lo, tx_hi), 1'b0, done);
         k++;
      end
      start = 1'b0;
      tick();
      check("idle_busy", busy, 1'b0);
      check("idle_counter_reset", counter_reset, 1'b1);
      check("idle_lag_hold", lag_a, model_vec());
   endtask

   initial begin
      bit done;
      int k;
      reset = 1'b1; start = 1'b0; single_shot = 1'b0; tx_done = 1'b0;
      scan_en = '1; lag_tmp_a = '0; lag_len_a = '0; lag_inc_a = '0;
      integ_cycles = TW'(10);
      tick(); tick();
      check_reset_values("reset");
      reset = 1'b0;
      tick();
      check_reset_values("idle");

      // 5,7,9,5 on both channels, tx_done 3 cycles after capture
      scan_en = 2'b11; integ_cycles = TW'(10);
      set_ch(0, 5, 6, 2); set_ch(1, 5, 6, 2);
      run_sweep(1'b0, 3, 3);

      // ch1 wraps at step 2, ch0 at step 4; single shot
      set_ch(0, 0, 4, 1); set_ch(1, 10, 2, 1);
      run_sweep(1'b1, 0, 4);

      // ch1 disabled holds tmp; ch0 inc=0 completes on the first step
      scan_en = 2'b01;
      set_ch(0, 7, 5, 0); set_ch(1, 3, 9, 4);
      run_sweep(1'b1, 0, 2);
      scan_en = 2'b01;
      set_ch(0, 2, 5, 2); set_ch(1, 3, 9, 4);
      run_sweep(1'b1, 0, 2);

      // integ_cycles=0 and a sweep at the top of the lag range
      scan_en = 2'b11; integ_cycles = '0;
      set_ch(0, 20'hFFFFF, 2, 1); set_ch(1, 20'hFFFFE, 4, 1);
      run_sweep(1'b1, 0, 2);

      // start dropped in the third integrate cycle
      integ_cycles = TW'(8); single_shot = 1'b0;
      set_ch(0, 11, 6, 1); set_ch(1, 12, 6, 2);
      start = 1'b1; model_start(); tick();
      k = 0;
      while (!integrating && k < 50) begin k++; tick(); end
      tick(); tick();
      start = 1'b0;
      tick();
      check("abort_outs", {busy, integrating, capture}, 3'b000);
      check("abort_lag", lag_a, model_vec());
      repeat (3) begin tick(); check("abort_no_capture", capture, 1'b0); end

      // start dropped in WAIT_TX: packet completes, STEP, then IDLE
      set_ch(0, 1, 9, 3); set_ch(1, 4, 3, 1);
      start = 1'b1; model_start(); tick();
      packet(3, 1'b1, done);

      // reset during WAIT_TX, then a late tx_done
      set_ch(0, 6, 9, 3); set_ch(1, 8, 3, 1);
      start = 1'b1; model_start(); tick();
      k = 0;
      while (!capture && k < 50) begin k++; tick(); end
      tick();
      start = 1'b0; reset = 1'b1;
      #1;
      check_reset_values("async_reset");
      tick();
      reset = 1'b0; tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      tick();
      check_reset_values("after_reset_tx");

      // randomized sweeps
      for (int r = 0; r < 12; r++) begin
         scan_en      = N'($urandom_range(0, 3));
         integ_cycles = TW'($urandom_range(0, 6));
         for (int i = 0; i < N; i++)
            set_ch(i, LW'($urandom_range(0, 40)), LW'($urandom_range(0, 12)),
                   IW'($urandom_range(0, 5)));
         run_sweep(1'($urandom_range(0, 1)), 0, 4);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
